// File: rtl/dec_pkg.sv
// dec_pkg: shared types and helpers for the sequential binary-to-decimal
// converter.
//   ASCII_ZERO / ASCII_SPACE : characters used when formatting digits
//   MAX_D                    : largest digit count fmt_digits can format
//   conv_state_e             : converter FSM states
//   fmt_digits()             : BCD vector -> ASCII digit vector, optional
//                              leading-zero blanking
package dec_pkg;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam int         MAX_D       = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } conv_state_e;

  // Formats the low nd nibbles of bcd as ASCII, digit 0 in the low byte.
  // Scanning from the most significant digit, zeros become spaces until the
  // first nonzero digit when blank is set. Digit 0 is always printed so a
  // zero value reads "0". Bytes at and above nd are returned as 8'h00.
  function automatic logic [MAX_D*8-1:0] fmt_digits(
    input logic [MAX_D*4-1:0] bcd,
    input int                 nd,
    input logic               blank
  );
    logic [MAX_D*8-1:0] res;
    logic [3:0]         dig;
    logic               lead;
    res  = '0;
    lead = blank;
    for (int i = MAX_D - 1; i >= 0; i--) begin
      dig = bcd[i*4 +: 4];
      if (i < nd) begin
        if (lead && (dig == 4'd0) && (i != 0)) begin
          res[i*8 +: 8] = ASCII_SPACE;
        end else begin
          res[i*8 +: 8] = ASCII_ZERO + {4'd0, dig};
          lead          = 1'b0;
        end
      end else begin
        res[i*8 +: 8] = 8'h00;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/bin_to_dec_seq_dabble_step.sv
// dabble_step: one combinational double-dabble iteration.
//   i_bcd [D*4-1:0] : current BCD accumulator (D digits)
//   i_bin [W-1:0]   : remaining binary value, MSB shifts out next
//   o_bcd [D*4-1:0] : accumulator after add-3 adjust and shift-left
//   o_bin [W-1:0]   : binary value shifted left by one
module dabble_step
  import dec_pkg::*;
#(
  parameter int D = 5,
  parameter int W = 16
) (
  input  logic [D*4-1:0] i_bcd,
  input  logic [W-1:0]   i_bin,
  output logic [D*4-1:0] o_bcd,
  output logic [W-1:0]   o_bin
);

  logic [D*4-1:0] w_adj;

  // Nibbles of 5 or more get +3 so the following doubling carries into the
  // next decimal digit.
  always_comb begin
    w_adj = i_bcd;
    for (int d = 0; d < D; d++) begin
      if (i_bcd[d*4 +: 4] >= 4'd5) begin
        w_adj[d*4 +: 4] = i_bcd[d*4 +: 4] + 4'd3;
      end else begin
        w_adj[d*4 +: 4] = i_bcd[d*4 +: 4];
      end
    end
  end

  // The top adjusted bit always drops off: the digit count is sized so the
  // value never reaches it.
  assign o_bcd = {w_adj[D*4-2:0], i_bin[W-1]};
  assign o_bin = {i_bin[W-2:0], 1'b0};

endmodule

// File: rtl/bin_to_dec_seq.sv
// bin_to_dec_seq: iterative (double dabble) binary to ASCII decimal converter.
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   start_i         : conversion request, sampled only while idle
//   sum_i, n_i      : binary sum and remaining count to convert
//   busy_o          : conversion in progress
//   done_o          : one-cycle pulse, dec_o/n_dec_o updated in that cycle
//   dec_o, n_dec_o  : ASCII digits, index 0 = least significant digit
// Both channels run SUM_W iterations in lockstep; the count is zero-extended
// so its result equals an N_W-iteration conversion.
module bin_to_dec_seq
  import dec_pkg::*;
#(
  parameter int SUM_W    = 16,
  parameter int SUM_D    = 5,
  parameter int N_W      = 8,
  parameter int N_D      = 3,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic [SUM_W-1:0]      sum_i,
  input  logic [N_W-1:0]        n_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [SUM_D-1:0][7:0] dec_o,
  output logic [N_D-1:0][7:0]   n_dec_o
);

  localparam int CNT_W = (SUM_W > 1) ? $clog2(SUM_W) : 1;

  // Formatted zero shown after reset.
  localparam logic [SUM_D-1:0][7:0] ZERO_SUM =
    (SUM_D*8)'(fmt_digits('0, SUM_D, BLANK_LZ));
  localparam logic [N_D-1:0][7:0] ZERO_N =
    (N_D*8)'(fmt_digits('0, N_D, BLANK_LZ));

  if ((64'd10 ** SUM_D) <= (64'd1 << SUM_W)) begin : g_chk_sum_d
    $error("SUM_D digits cannot hold a SUM_W-bit value");
  end
  if ((64'd10 ** N_D) <= (64'd1 << N_W)) begin : g_chk_n_d
    $error("N_D digits cannot hold an N_W-bit value");
  end
  if (N_W > SUM_W) begin : g_chk_n_w
    $error("N_W must not exceed SUM_W");
  end
  if ((SUM_D > MAX_D) || (N_D > MAX_D)) begin : g_chk_max_d
    $error("digit count exceeds MAX_D");
  end

  conv_state_e      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [SUM_W-1:0] r_bin_sum;
  logic [SUM_W-1:0] r_bin_n;
  logic [SUM_D*4-1:0] r_bcd_sum;
  logic [N_D*4-1:0]   r_bcd_n;

  logic [SUM_W-1:0]   w_bin_sum_nxt;
  logic [SUM_W-1:0]   w_bin_n_nxt;
  logic [SUM_D*4-1:0] w_bcd_sum_nxt;
  logic [N_D*4-1:0]   w_bcd_n_nxt;

  dabble_step #(.D(SUM_D), .W(SUM_W)) u_step_sum (
    .i_bcd (r_bcd_sum),
    .i_bin (r_bin_sum),
    .o_bcd (w_bcd_sum_nxt),
    .o_bin (w_bin_sum_nxt)
  );

  dabble_step #(.D(N_D), .W(SUM_W)) u_step_n (
    .i_bcd (r_bcd_n),
    .i_bin (r_bin_n),
    .o_bcd (w_bcd_n_nxt),
    .o_bin (w_bin_n_nxt)
  );

  // Converter FSM: load in IDLE, SUM_W iterations in CONV, publish in DONE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bin_sum <= '0;
      r_bin_n   <= '0;
      r_bcd_sum <= '0;
      r_bcd_n   <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      dec_o     <= ZERO_SUM;
      n_dec_o   <= ZERO_N;
    end else begin
      case (r_state)
        IDLE: begin
          done_o <= 1'b0;
          if (start_i) begin
            r_bin_sum <= sum_i;
            r_bin_n   <= SUM_W'(n_i);
            r_bcd_sum <= '0;
            r_bcd_n   <= '0;
            r_cnt     <= CNT_W'(SUM_W - 1);
            busy_o    <= 1'b1;
            r_state   <= CONV;
          end else begin
            busy_o <= 1'b0;
          end
        end
        CONV: begin
          r_bin_sum <= w_bin_sum_nxt;
          r_bin_n   <= w_bin_n_nxt;
          r_bcd_sum <= w_bcd_sum_nxt;
          r_bcd_n   <= w_bcd_n_nxt;
          if (r_cnt == '0) begin
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        DONE: begin
          // busy_o stays high through the done_o cycle.
          dec_o   <= (SUM_D*8)'(fmt_digits((MAX_D*4)'(r_bcd_sum), SUM_D, BLANK_LZ));
          n_dec_o <= (N_D*8)'(fmt_digits((MAX_D*4)'(r_bcd_n), N_D, BLANK_LZ));
          done_o  <= 1'b1;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          busy_o  <= 1'b0;
          done_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule
